// File: rtl/instr_encode_loader_if.sv
// Field-input, memory-write and status bundle of the instruction encode loader.
// The master side drives jobs and instruction fields; the slave side is the loader.
interface instr_encode_loader_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              i_start;
   logic [ADDR_W-1:0] i_base_addr;
   logic [ADDR_W-1:0] i_count;
   logic              i_valid;
   logic              o_ready;
   logic [3:0]        i_opcode;
   logic [3:0]        i_srcadd_1;
   logic [3:0]        i_srcadd_2;
   logic [3:0]        i_destadd;
   logic              o_mem_we;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [15:0]       o_mem_wdata;
   logic              i_mem_ready;
   logic              o_busy;
   logic              o_done;
   logic              o_wrapped;

   modport master (
      output i_start, i_base_addr, i_count, i_valid,
      output i_opcode, i_srcadd_1, i_srcadd_2, i_destadd, i_mem_ready,
      input  o_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_done, o_wrapped
   );

   modport slave (
      input  i_start, i_base_addr, i_count, i_valid,
      input  i_opcode, i_srcadd_1, i_srcadd_2, i_destadd, i_mem_ready,
      output o_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_done, o_wrapped
   );
endinterface

// File: rtl/instr_encode_loader.sv
// Packs opcode/register fields into 16-bit words, buffers them in a small FIFO and
// writes them to consecutive instruction-memory addresses starting at a job base.
module instr_encode_loader #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   instr_encode_loader_if.slave  bus
);

   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned WORD_W = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q, state_n;

   logic [WORD_W-1:0] fifo_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_n;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_n;
   logic [CNT_W-1:0]  occ_q, occ_n;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_n;
   logic [ADDR_W-1:0] rem_in_q, rem_in_n;
   logic [ADDR_W-1:0] rem_out_q, rem_out_n;
   logic              wrapped_q, wrapped_n;

   logic              ready_q, ready_n;
   logic              mem_we_q, mem_we_n;
   logic [WORD_W-1:0] wdata_q, wdata_n;
   logic              busy_q, busy_n;
   logic              done_q, done_n;

   logic              start_ok;
   logic              push;
   logic              pop;
   logic              last_pop;
   logic [WORD_W-1:0] word;
   logic [WORD_W-1:0] head_n;

   assign word     = {bus.i_opcode, bus.i_srcadd_1, bus.i_srcadd_2, bus.i_destadd};
   assign start_ok = (state_q == S_IDLE) && bus.i_start;
   // ready/we registers are only ever set in LOAD, so they double as the state qualifier
   assign push     = bus.i_valid && ready_q;
   assign pop      = mem_we_q && bus.i_mem_ready;
   assign last_pop = pop && (rem_out_q == ADDR_W'(1));

   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_n = (bus.i_count != '0) ? S_LOAD : S_DONE;
            end
         end
         S_LOAD: begin
            if (last_pop) begin
               state_n = S_DONE;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Datapath next values: FIFO pointers, occupancy, job counters, wrap flag
   always_comb begin
      wr_ptr_n  = wr_ptr_q;
      rd_ptr_n  = rd_ptr_q;
      occ_n     = occ_q;
      wr_addr_n = wr_addr_q;
      rem_in_n  = rem_in_q;
      rem_out_n = rem_out_q;
      wrapped_n = wrapped_q;

      if (push) begin
         wr_ptr_n = wr_ptr_q + PTR_W'(1);
         rem_in_n = rem_in_q - ADDR_W'(1);
      end
      if (pop) begin
         rd_ptr_n  = rd_ptr_q + PTR_W'(1);
         wr_addr_n = wr_addr_q + ADDR_W'(1);
         rem_out_n = rem_out_q - ADDR_W'(1);
         if (wr_addr_q == '1) begin
            wrapped_n = 1'b1;
         end
      end
      case ({push, pop})
         2'b10:   occ_n = occ_q + CNT_W'(1);
         2'b01:   occ_n = occ_q - CNT_W'(1);
         default: occ_n = occ_q;
      endcase

      if (start_ok) begin
         wr_addr_n = bus.i_base_addr;
         rem_in_n  = bus.i_count;
         rem_out_n = bus.i_count;
         wrapped_n = 1'b0;
      end
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      ready_n  = 1'b0;
      mem_we_n = 1'b0;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      wdata_n  = wdata_q;
      // a word pushed into the slot that becomes the head bypasses the array
      head_n   = (push && (rd_ptr_n == wr_ptr_q)) ? word : fifo_mem[rd_ptr_n];

      case (state_n)
         S_LOAD: begin
            busy_n   = 1'b1;
            ready_n  = (occ_n != CNT_W'(DEPTH)) && (rem_in_n != '0);
            mem_we_n = (occ_n != '0);
         end
         S_DONE: begin
            busy_n = 1'b1;
            done_n = 1'b1;
         end
         default: ;
      endcase

      if (mem_we_n) begin
         wdata_n = head_n;
      end
   end

   // Control and output registers
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         occ_q     <= '0;
         wr_addr_q <= '0;
         rem_in_q  <= '0;
         rem_out_q <= '0;
         wrapped_q <= 1'b0;
         ready_q   <= 1'b0;
         mem_we_q  <= 1'b0;
         wdata_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_n;
         rd_ptr_q  <= rd_ptr_n;
         occ_q     <= occ_n;
         wr_addr_q <= wr_addr_n;
         rem_in_q  <= rem_in_n;
         rem_out_q <= rem_out_n;
         wrapped_q <= wrapped_n;
         ready_q   <= ready_n;
         mem_we_q  <= mem_we_n;
         wdata_q   <= wdata_n;
         busy_q    <= busy_n;
         done_q    <= done_n;
      end
   end

   // FIFO storage needs no reset; occupancy guards every read
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= word;
      end
   end

   assign bus.o_ready     = ready_q;
   assign bus.o_mem_we    = mem_we_q;
   assign bus.o_mem_addr  = wr_addr_q;
   assign bus.o_mem_wdata = wdata_q;
   assign bus.o_busy      = busy_q;
   assign bus.o_done      = done_q;
   assign bus.o_wrapped   = wrapped_q;

endmodule
